// File: rtl/mem_map_pkg.sv
// Shared definitions for the 6502 memory-bus sequencer.
//   RAM_NIB / ROM_NIB : address[15:12] values that select RAM and ROM
//   UNMAP_DAT         : read data returned for unmapped regions
//   RESET_VEC         : address of the 6502 reset vector (lives in ROM)
//   state_e           : sequencer FSM encoding
//   req_t             : a request as held while it is in flight
package mem_map_pkg;

  localparam logic [3:0]  RAM_NIB   = 4'h0;
  localparam logic [3:0]  ROM_NIB   = 4'hF;
  localparam logic [7:0]  UNMAP_DAT = 8'h00;
  localparam logic [15:0] RESET_VEC = 16'hFFFC;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAPT  = 3'd2,
    WR_ISSUE = 3'd3,
    TURN     = 3'd4
  } state_e;

  // Region flags are decoded once at accept and travel with the request.
  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        ram;
    logic        rom;
  } req_t;

endpackage

// File: rtl/mem_decode.sv
// Address-region decoder.
//   nib_i : address[15:12]
//   ram_o : region is RAM (read/write)
//   rom_o : region is ROM (read-only)
// Anything that is neither is unmapped.
module mem_decode #(
  parameter logic [3:0] RAM_NIB = mem_map_pkg::RAM_NIB,
  parameter logic [3:0] ROM_NIB = mem_map_pkg::ROM_NIB
) (
  input  logic [3:0] nib_i,
  output logic       ram_o,
  output logic       rom_o
);

  assign ram_o = (nib_i == RAM_NIB);
  assign rom_o = (nib_i == ROM_NIB);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus sequencer between the 6502 core request interface and the mem block.
// One request in flight at a time (valid/ready); a registered one-cycle
// response pulse carries read data or a write acknowledge plus an error flag.
//   ph1                     : clock, all state on posedge
//   reset                   : asynchronous, active low
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_addr/req_we/req_wdata : request fields
//   rsp_valid/rsp_rdata/rsp_err : response pulse
//   bus_address/bus_rw_sel  : to mem (rw_sel 1 = read, 0 = write)
//   bus_data                : shared data bus, driven here only when writing
module mem_bus_ctrl #(
  parameter logic [3:0] RAM_NIB   = mem_map_pkg::RAM_NIB,
  parameter logic [3:0] ROM_NIB   = mem_map_pkg::ROM_NIB,
  parameter logic [7:0] UNMAP_DAT = mem_map_pkg::UNMAP_DAT
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] bus_address,
  output logic        bus_rw_sel,
  inout  wire  [7:0]  bus_data
);

  import mem_map_pkg::*;

  state_e      state_q;
  req_t        req_q;
  logic        last_rd_q;      // last completed op was a read
  logic [15:0] bus_address_q;
  logic        bus_rw_sel_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        rsp_err_q;
  logic        dec_ram, dec_rom;

  // Decode the incoming address; the flags are latched into req_q at accept
  // so a direct IDLE->WR_ISSUE transition can already gate the bus write.
  mem_decode #(
    .RAM_NIB (RAM_NIB),
    .ROM_NIB (ROM_NIB)
  ) u_dec (
    .nib_i (req_addr[15:12]),
    .ram_o (dec_ram),
    .rom_o (dec_rom)
  );

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      req_q         <= '0;
      last_rd_q     <= 1'b0;
      bus_address_q <= 16'h0000;
      bus_rw_sel_q  <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      rsp_err_q     <= 1'b0;
    end else begin
      // Response is a single-cycle pulse; everything falls back to zero.
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q <= '{addr: req_addr, we: req_we, wdata: req_wdata,
                       ram: dec_ram, rom: dec_rom};
            if (!req_we) begin
              bus_address_q <= req_addr;
              bus_rw_sel_q  <= 1'b1;
              state_q       <= RD_ISSUE;
            end else if (last_rd_q) begin
              // mem may still be driving the previous read's data; hold the
              // bus in read mode for one cycle before turning it around.
              state_q <= TURN;
            end else begin
              bus_address_q <= req_addr;
              bus_rw_sel_q  <= !dec_ram;
              state_q       <= WR_ISSUE;
            end
          end
        end
        RD_ISSUE: state_q <= RD_CAPT;   // mem registers data_out at this edge
        RD_CAPT: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= (req_q.ram | req_q.rom) ? bus_data : UNMAP_DAT;
          rsp_err_q   <= !(req_q.ram | req_q.rom);
          last_rd_q   <= !req_q.we;
          state_q     <= IDLE;
        end
        TURN: begin
          bus_address_q <= req_q.addr;
          bus_rw_sel_q  <= !req_q.ram;
          state_q       <= WR_ISSUE;
        end
        WR_ISSUE: begin
          // mem captures the write at this edge when rw_sel is low.
          rsp_valid_q  <= 1'b1;
          rsp_err_q    <= !req_q.ram;
          bus_rw_sel_q <= 1'b1;
          last_rd_q    <= !req_q.we;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign bus_address = bus_address_q;
  assign bus_rw_sel  = bus_rw_sel_q;

  // Only driver on the bus from this side; released whenever mem may drive.
  assign bus_data = bus_rw_sel_q ? 8'bz : req_q.wdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_we;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] bus_address;
  logic        bus_rw_sel;
  wire  [7:0]  bus_data;

  always #5 ph1 = ~ph1;

  mem_bus_ctrl dut (
    .ph1         (ph1),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .bus_address (bus_address),
    .bus_rw_sel  (bus_rw_sel),
    .bus_data    (bus_data)
  );

  // ROM contents: reset vector -> 0xF000, everything else a fixed pattern.
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'h00;
    if (a == 16'hFFFD) return 8'hF0;
    return a[7:0] ^ 8'hA5;
  endfunction

  // ---- mem block model: registered data_out, drives bus in read mode ----
  logic [7:0] mem_ram [4096];
  logic [7:0] mem_dout;
  assign bus_data = bus_rw_sel ? mem_dout : 8'bz;

  always @(posedge ph1) begin
    if (bus_rw_sel === 1'b0 && bus_address[15:12] == 4'h0)
      mem_ram[bus_address[11:0]] <= bus_data;
    if (bus_address[15:12] == 4'h0)      mem_dout <= mem_ram[bus_address[11:0]];
    else if (bus_address[15:12] == 4'hF) mem_dout <= rom_byte(bus_address);
    else                                 mem_dout <= 8'h00;
  end

  int rw_low_cnt = 0;
  always @(posedge ph1) if (bus_rw_sel === 1'b0) rw_low_cnt <= rw_low_cnt + 1;

  // ---- reference model: memory map + latency rules ----
  logic [7:0] ref_ram [4096];
  bit         ref_last_rd;

  task automatic ref_op(input logic [15:0] a, input logic we, input logic [7:0] d,
                        output logic [7:0] rd, output logic err, output int lat);
    bit is_ram = (a[15:12] == 4'h0);
    bit is_rom = (a[15:12] == 4'hF);
    if (!we) begin
      lat = 2;
      rd  = is_ram ? ref_ram[a[11:0]] : (is_rom ? rom_byte(a) : 8'h00);
      err = !(is_ram || is_rom);
      ref_last_rd = 1;
    end else begin
      lat = ref_last_rd ? 2 : 1;
      rd  = 8'h00;
      err = !is_ram;
      if (is_ram) ref_ram[a[11:0]] = d;
      ref_last_rd = 0;
    end
  endtask

  int n_cmp = 0;
  int n_err = 0;

  // Drive one request, wait for accept, return edges-to-response and payload.
  task automatic do_req(input logic [15:0] a, input logic we, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output logic e);
    int guard = 0;
    @(negedge ph1);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = d;
    while (!req_ready && guard < 20) begin @(negedge ph1); guard++; end
    @(posedge ph1); #1;
    req_valid = 1'b0;
    lat = 0; rd = 8'h00; e = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge ph1); #1;
      if (rsp_valid) begin lat = k; rd = rsp_rdata; e = rsp_err; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge ph1);
    n_cmp += 6;
    if (req_ready !== 1'b1)      begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    if (rsp_valid !== 1'b0)      begin n_err++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    if (rsp_rdata !== 8'h00)     begin n_err++; $display("FAIL rst_rdata: got %h want 00", rsp_rdata); end
    if (rsp_err !== 1'b0)        begin n_err++; $display("FAIL rst_err: got %b want 0", rsp_err); end
    if (bus_address !== 16'h0)   begin n_err++; $display("FAIL rst_addr: got %h want 0000", bus_address); end
    if (bus_rw_sel !== 1'b1)     begin n_err++; $display("FAIL rst_rwsel: got %b want 1", bus_rw_sel); end
    reset = 1'b1;
    ref_last_rd = 0;
  endtask

  task automatic test_reset_mid_write();
    @(negedge ph1);
    req_valid = 1'b1; req_addr = 16'h0020; req_we = 1'b1; req_wdata = 8'hC3;
    @(posedge ph1); #1;
    req_valid = 1'b0;
    n_cmp += 2;
    if (bus_rw_sel !== 1'b0) begin n_err++; $display("FAIL midwr_rwsel_low: got %b want 0", bus_rw_sel); end
    if (bus_data !== 8'hC3)  begin n_err++; $display("FAIL midwr_data: got %h want c3", bus_data); end
    #2 reset = 1'b0;
    #1;
    n_cmp += 5;
    if (bus_rw_sel !== 1'b1)   begin n_err++; $display("FAIL midwr_rwsel: got %b want 1", bus_rw_sel); end
    if (bus_data !== mem_dout) begin n_err++; $display("FAIL midwr_bus: got %h want mem %h", bus_data, mem_dout); end
    if (rsp_valid !== 1'b0)    begin n_err++; $display("FAIL midwr_valid: got %b want 0", rsp_valid); end
    if (req_ready !== 1'b1)    begin n_err++; $display("FAIL midwr_ready: got %b want 1", req_ready); end
    if (bus_address !== 16'h0) begin n_err++; $display("FAIL midwr_addr: got %h want 0000", bus_address); end
    @(negedge ph1);
    reset = 1'b1;
    ref_last_rd = 0;
  endtask

  task automatic test_wr_rd();
    int lat; logic [7:0] rd; logic e;
    logic [7:0] xr; logic xe; int xl;
    ref_op(16'h0010, 1'b1, 8'h5A, xr, xe, xl);
    do_req(16'h0010, 1'b1, 8'h5A, lat, rd, e);
    n_cmp += 2;
    if (lat !== xl) begin n_err++; $display("FAIL wr_lat: got %0d want %0d", lat, xl); end
    if (e !== xe)   begin n_err++; $display("FAIL wr_err: got %b want %b", e, xe); end
    ref_op(16'h0010, 1'b0, 8'h00, xr, xe, xl);
    do_req(16'h0010, 1'b0, 8'h00, lat, rd, e);
    n_cmp += 3;
    if (rd !== 8'h5A) begin n_err++; $display("FAIL rd_data: got %h want 5a", rd); end
    if (e !== 1'b0)   begin n_err++; $display("FAIL rd_err: got %b want 0", e); end
    if (lat !== 2)    begin n_err++; $display("FAIL rd_lat: got %0d want 2", lat); end
    @(posedge ph1); #1;
    n_cmp += 2;
    if (rsp_valid !== 1'b0)  begin n_err++; $display("FAIL pulse_valid: got %b want 0", rsp_valid); end
    if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL pulse_rdata: got %h want 00", rsp_rdata); end
  endtask

  task automatic test_rom_vector();
    int lat; logic [7:0] rd; logic e;
    logic [7:0] xr; logic xe; int xl;
    ref_op(16'hFFFC, 1'b0, 8'h00, xr, xe, xl);
    do_req(16'hFFFC, 1'b0, 8'h00, lat, rd, e);
    n_cmp += 2;
    if (rd !== 8'h00 || e !== 1'b0) begin n_err++; $display("FAIL vec_lo: got %h/%b want 00/0", rd, e); end
    if (lat !== xl) begin n_err++; $display("FAIL vec_lo_lat: got %0d want %0d", lat, xl); end
    ref_op(16'hFFFD, 1'b0, 8'h00, xr, xe, xl);
    do_req(16'hFFFD, 1'b0, 8'h00, lat, rd, e);
    n_cmp += 1;
    if (rd !== 8'hF0 || e !== 1'b0) begin n_err++; $display("FAIL vec_hi: got %h/%b want f0/0", rd, e); end
  endtask

  task automatic test_rom_write();
    int lat; logic [7:0] rd; logic e; int low0;
    logic [7:0] xr; logic xe; int xl;
    low0 = rw_low_cnt;
    ref_op(16'hF000, 1'b1, 8'h77, xr, xe, xl);
    do_req(16'hF000, 1'b1, 8'h77, lat, rd, e);
    n_cmp += 3;
    if (e !== 1'b1)          begin n_err++; $display("FAIL romwr_err: got %b want 1", e); end
    if (lat !== xl)          begin n_err++; $display("FAIL romwr_lat: got %0d want %0d", lat, xl); end
    if (rw_low_cnt !== low0) begin n_err++; $display("FAIL romwr_nowrite: got %0d low cycles want 0", rw_low_cnt - low0); end
    ref_op(16'hF000, 1'b0, 8'h00, xr, xe, xl);
    do_req(16'hF000, 1'b0, 8'h00, lat, rd, e);
    n_cmp += 1;
    if (rd !== xr || e !== 1'b0) begin n_err++; $display("FAIL rom_keep: got %h/%b want %h/0", rd, e, xr); end
  endtask

  task automatic test_unmapped();
    int lat; logic [7:0] rd; logic e;
    logic [7:0] xr; logic xe; int xl;
    ref_op(16'h8000, 1'b0, 8'h00, xr, xe, xl);
    do_req(16'h8000, 1'b0, 8'h00, lat, rd, e);
    n_cmp += 2;
    if (rd !== 8'h00 || e !== 1'b1) begin n_err++; $display("FAIL unmap_rd: got %h/%b want 00/1", rd, e); end
    if (lat !== 2) begin n_err++; $display("FAIL unmap_lat: got %0d want 2", lat); end
  endtask

  task automatic test_turnaround();
    int lat; logic [7:0] rd; logic e; int low0;
    logic [7:0] xr; logic xe; int xl;
    ref_op(16'h0010, 1'b0, 8'h00, xr, xe, xl);
    do_req(16'h0010, 1'b0, 8'h00, lat, rd, e);
    n_cmp += 1;
    if (rd !== xr) begin n_err++; $display("FAIL turn_rd: got %h want %h", rd, xr); end
    low0 = rw_low_cnt;
    ref_op(16'h0011, 1'b1, 8'h3C, xr, xe, xl);
    do_req(16'h0011, 1'b1, 8'h3C, lat, rd, e);
    n_cmp += 3;
    if (lat !== 2) begin n_err++; $display("FAIL turn_lat: got %0d want 2", lat); end
    if (e !== 1'b0) begin n_err++; $display("FAIL turn_err: got %b want 0", e); end
    if (rw_low_cnt - low0 !== 1) begin n_err++; $display("FAIL turn_lowcyc: got %0d want 1", rw_low_cnt - low0); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] rd; logic e;
    logic [7:0] xr; logic xe; int xl;
    ref_op(16'h0012, 1'b1, 8'h81, xr, xe, xl);
    do_req(16'h0012, 1'b1, 8'h81, lat, rd, e);
    n_cmp += 1;
    if (lat !== 1) begin n_err++; $display("FAIL b2b_wr_lat: got %0d want 1", lat); end
    ref_op(16'h0011, 1'b0, 8'h00, xr, xe, xl);
    do_req(16'h0011, 1'b0, 8'h00, lat, rd, e);
    n_cmp += 1;
    if (rd !== 8'h3C) begin n_err++; $display("FAIL b2b_rd: got %h want 3c", rd); end
  endtask

  task automatic test_random();
    int lat; logic [7:0] rd; logic e;
    logic [7:0] xr; logic xe; int xl;
    logic [15:0] a; logic we; logic [7:0] d;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = 16'h0040 + 16'($urandom_range(0, 31));
        2:       a = {4'hF, 12'($urandom)};
        default: a = {4'($urandom_range(1, 14)), 12'($urandom)};
      endcase
      we = 1'($urandom);
      d  = 8'($urandom);
      ref_op(a, we, d, xr, xe, xl);
      do_req(a, we, d, lat, rd, e);
      n_cmp += 3;
      if (rd !== xr)  begin n_err++; $display("FAIL rnd_data[%0d] a=%h we=%b: got %h want %h", i, a, we, rd, xr); end
      if (e !== xe)   begin n_err++; $display("FAIL rnd_err[%0d] a=%h we=%b: got %b want %b", i, a, we, e, xe); end
      if (lat !== xl) begin n_err++; $display("FAIL rnd_lat[%0d] a=%h we=%b: got %0d want %0d", i, a, we, lat, xl); end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_addr = 16'h0; req_we = 1'b0; req_wdata = 8'h0;
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      mem_ram[i] = 8'($urandom);
      ref_ram[i] = mem_ram[i];
    end
    // While mem owns the bus, the resolved bus must be exactly mem's data.
    fork
      forever begin
        @(negedge ph1);
        if (bus_rw_sel === 1'b1) begin
          n_cmp++;
          if (bus_data !== mem_dout) begin
            n_err++;
            $display("FAIL bus_contention: bus_data=%h want mem %h", bus_data, mem_dout);
          end
        end
      end
    join_none
    test_reset();
    test_reset_mid_write();
    test_wr_rd();
    test_rom_vector();
    test_rom_write();
    test_unmapped();
    test_turnaround();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge ph1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
